// File: rtl/tx_pulser_pkg.sv
// Shared types, defaults and sizing helper for the multi-channel key pulser.
package tx_pulser_pkg;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_HELD = 1'b1
    } ch_state_t;

    localparam int unsigned DEF_CHANNELS        = 4;
    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000;
    localparam int unsigned DEF_REPEAT_DELAY    = 500000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 100000;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tx_pulser_channel.sv
// One key: synchroniser, debounce counter, idle/held FSM, optional auto-repeat (TX_PULSER_AUTOREPEAT_EN).
// Latency: press steady -> pulse_out after SYNC_STAGES+DEBOUNCE_CYCLES edges; no backpressure, strobes are fire-and-forget.
module tx_pulser_channel
    import tx_pulser_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic pulse_nxt,
    output logic pulse_out,
    output logic key_held
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    ch_state_t              state_q, state_d;
    logic                   pulse_q, pulse_d;
    logic                   differ;

`ifdef TX_PULSER_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = cnt_width(RPT_MAX);
    localparam logic [RW-1:0] RPT_DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rpt_q, rpt_d;
    logic          rpt_first_q, rpt_first_d;
`else
    logic unused_rpt_cfg;
    assign unused_rpt_cfg = (REPEAT_DELAY != REPEAT_PERIOD);
`endif

    // Sync flops preset to released so a key held through reset is seen as a fresh press.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], key_n};
    assign differ = (~sync_q[SYNC_STAGES-1]) != (state_q == CH_HELD);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (differ) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                state_d = (state_q == CH_HELD) ? CH_IDLE : CH_HELD;
                pulse_d = (state_q == CH_IDLE);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
`ifdef TX_PULSER_AUTOREPEAT_EN
        rpt_d       = rpt_q;
        rpt_first_d = rpt_first_q;
        // Repeats only while staying held; the release edge itself never pulses.
        if ((state_q == CH_HELD) && (state_d == CH_HELD)) begin
            if ((rpt_first_q && (rpt_q == RPT_DELAY_LAST)) ||
                (!rpt_first_q && (rpt_q == RPT_PERIOD_LAST))) begin
                pulse_d     = 1'b1;
                rpt_d       = '0;
                rpt_first_d = 1'b0;
            end else begin
                rpt_d = rpt_q + RW'(1);
            end
        end else begin
            rpt_d       = '0;
            rpt_first_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '1;
            cnt_q   <= '0;
            state_q <= CH_IDLE;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            pulse_q <= pulse_d;
        end
    end

`ifdef TX_PULSER_AUTOREPEAT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rpt_q       <= '0;
            rpt_first_q <= 1'b1;
        end else begin
            rpt_q       <= rpt_d;
            rpt_first_q <= rpt_first_d;
        end
    end
`endif

    assign pulse_nxt = pulse_d;
    assign pulse_out = pulse_q;
    assign key_held  = (state_q == CH_HELD);

endmodule

// File: rtl/tx_debounce_pulser.sv
// N-channel debounced key pulser for the tx control path; auto-repeat via TX_PULSER_AUTOREPEAT_EN.
// Latency: SYNC_STAGES+DEBOUNCE_CYCLES edges from steady press to strobe; no backpressure, strobes always emitted.
module tx_debounce_pulser
    import tx_pulser_pkg::*;
#(
    parameter int unsigned CHANNELS        = DEF_CHANNELS,
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] key_n,
    output logic [CHANNELS-1:0] pulse_out,
    output logic [CHANNELS-1:0] key_held,
    output logic                pulse_any
);

    logic [CHANNELS-1:0] pulse_nxt;
    logic                pulse_any_q, pulse_any_d;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        tx_pulser_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .key_n     (key_n[i]),
            .pulse_nxt (pulse_nxt[i]),
            .pulse_out (pulse_out[i]),
            .key_held  (key_held[i])
        );
    end

    // Built from the channels' next-state strobes so it lands on the same cycle as pulse_out.
    assign pulse_any_d = |pulse_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_any_q <= 1'b0;
        end else begin
            pulse_any_q <= pulse_any_d;
        end
    end

    assign pulse_any = pulse_any_q;

endmodule
